// File: rtl/risc_v_32_i_pkg.sv
// Shared RV32I control definitions: controller states, opcodes, datapath mux encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package risc_v_32_i_pkg;

    typedef enum logic [2:0] {
        IMM_I_TYPE,
        IMM_S_TYPE,
        IMM_B_TYPE,
        IMM_U_TYPE,
        IMM_J_TYPE,
        IMM_UNKNOWN_TYPE
    } imm_select_e;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ALU_WB,
        ST_BRANCH,
        ST_JAL,
        ST_JALR,
        ST_LUI,
        ST_AUIPC,
        ST_FAULT
    } ctrl_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic       ADR_PC         = 1'b0;
    localparam logic       ADR_RESULT     = 1'b1;

    localparam logic [1:0] ALU_A_PC       = 2'b00;
    localparam logic [1:0] ALU_A_OLD_PC   = 2'b01;
    localparam logic [1:0] ALU_A_RS1      = 2'b10;

    localparam logic [1:0] ALU_B_RS2      = 2'b00;
    localparam logic [1:0] ALU_B_IMM      = 2'b01;
    localparam logic [1:0] ALU_B_FOUR     = 2'b10;

    localparam logic [1:0] ALU_OP_ADD     = 2'b00;
    localparam logic [1:0] ALU_OP_CMP     = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT   = 2'b10;
    localparam logic [1:0] ALU_OP_PASS_B  = 2'b11;

    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_READ_DATA  = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    // Every controller output except imm_sel, so a whole cycle's strobes can be zeroed at once.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       retire;
        logic       illegal;
    } ctrl_sig_t;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath/memory bundle; master is the controller, slave the datapath.
// Latency: n/a (wiring only).
// Backpressure: memory stalls the controller through mem_ready_i.
interface multi_cycle_controller_if;
    import risc_v_32_i_pkg::*;

    logic [6:0]  opcode_i;
    logic        mem_ready_i;
    logic        branch_taken_i;
    logic        mem_req_o;
    logic        mem_write_o;
    logic        adr_src_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic        reg_write_o;
    logic [1:0]  alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [1:0]  alu_op_o;
    logic [1:0]  result_src_o;
    imm_select_e imm_sel_o;
    logic        retire_o;
    logic        illegal_o;

    modport master (
        input  opcode_i, mem_ready_i, branch_taken_i,
        output mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_sel_o,
               retire_o, illegal_o
    );

    modport slave (
        output opcode_i, mem_ready_i, branch_taken_i,
        input  mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_sel_o,
               retire_o, illegal_o
    );

endinterface

// File: rtl/imm_select_decoder.sv
// Maps an RV32I opcode to the immediate format used by the sign-extend stage.
// Latency: purely combinational.
// Backpressure: none.
module imm_select_decoder
    import risc_v_32_i_pkg::*;
(
    input  logic [6:0]  opcode_i,
    output imm_select_e imm_sel_o
);

    always_comb begin
        imm_sel_o = IMM_UNKNOWN_TYPE;
        case (opcode_i)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_sel_o = IMM_I_TYPE;
            OPC_STORE:                      imm_sel_o = IMM_S_TYPE;
            OPC_BRANCH:                     imm_sel_o = IMM_B_TYPE;
            OPC_LUI, OPC_AUIPC:             imm_sel_o = IMM_U_TYPE;
            OPC_JAL:                        imm_sel_o = IMM_J_TYPE;
            default:                        imm_sel_o = IMM_UNKNOWN_TYPE;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore control FSM for a multi-cycle RV32I core.
// Latency: 3 (branch), 4 (ALU/store/JAL), 5 (load/JALR) cycles plus memory waits.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready_i.
module multi_cycle_controller
    import risc_v_32_i_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    multi_cycle_controller_if.master bus
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    ctrl_sig_t   ctrl_d;
    ctrl_sig_t   ctrl;
    imm_select_e imm_sel;

    imm_select_decoder u_imm_select_decoder (
        .opcode_i  (bus.opcode_i),
        .imm_sel_o (imm_sel)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (bus.mem_ready_i) state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode_i)
                    OPC_LOAD, OPC_STORE: state_d = ST_MEM_ADR;
                    OPC_OP:              state_d = ST_EXEC_R;
                    OPC_OP_IMM:          state_d = ST_EXEC_I;
                    OPC_BRANCH:          state_d = ST_BRANCH;
                    OPC_JAL:             state_d = ST_JAL;
                    OPC_JALR:            state_d = ST_JALR;
                    OPC_LUI:             state_d = ST_LUI;
                    OPC_AUIPC:           state_d = ST_AUIPC;
                    default:             state_d = ST_FAULT;
                endcase
            end
            ST_MEM_ADR:   state_d = (bus.opcode_i == OPC_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (bus.mem_ready_i) state_d = ST_MEM_WB;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: if (bus.mem_ready_i) state_d = ST_FETCH;
            ST_EXEC_R,
            ST_EXEC_I:    state_d = ST_ALU_WB;
            ST_ALU_WB:    state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            // JALR computes rs1+imm, then reuses JAL to load PC and link oldPC+4.
            ST_JALR:      state_d = ST_JAL;
            ST_JAL:       state_d = ST_ALU_WB;
            ST_LUI,
            ST_AUIPC:     state_d = ST_ALU_WB;
            ST_FAULT:     state_d = ST_FAULT;
            default:      state_d = ST_FAULT;
        endcase
    end

    always_comb begin
        ctrl_d = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl_d.mem_req    = 1'b1;
                ctrl_d.adr_src    = ADR_PC;
                ctrl_d.alu_src_a  = ALU_A_PC;
                ctrl_d.alu_src_b  = ALU_B_FOUR;
                ctrl_d.alu_op     = ALU_OP_ADD;
                ctrl_d.result_src = RES_ALU_RESULT;
                ctrl_d.ir_write   = bus.mem_ready_i;
                ctrl_d.pc_write   = bus.mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_d.alu_src_a  = ALU_A_OLD_PC;
                ctrl_d.alu_src_b  = ALU_B_IMM;
                ctrl_d.alu_op     = ALU_OP_ADD;
            end
            ST_MEM_ADR, ST_JALR: begin
                ctrl_d.alu_src_a  = ALU_A_RS1;
                ctrl_d.alu_src_b  = ALU_B_IMM;
                ctrl_d.alu_op     = ALU_OP_ADD;
            end
            ST_MEM_READ: begin
                ctrl_d.mem_req    = 1'b1;
                ctrl_d.adr_src    = ADR_RESULT;
                ctrl_d.result_src = RES_ALU_OUT;
            end
            ST_MEM_WB: begin
                ctrl_d.result_src = RES_READ_DATA;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.retire     = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl_d.mem_req    = 1'b1;
                ctrl_d.mem_write  = 1'b1;
                ctrl_d.adr_src    = ADR_RESULT;
                ctrl_d.result_src = RES_ALU_OUT;
                ctrl_d.retire     = bus.mem_ready_i;
            end
            ST_EXEC_R: begin
                ctrl_d.alu_src_a  = ALU_A_RS1;
                ctrl_d.alu_src_b  = ALU_B_RS2;
                ctrl_d.alu_op     = ALU_OP_FUNCT;
            end
            ST_EXEC_I: begin
                ctrl_d.alu_src_a  = ALU_A_RS1;
                ctrl_d.alu_src_b  = ALU_B_IMM;
                ctrl_d.alu_op     = ALU_OP_FUNCT;
            end
            ST_ALU_WB: begin
                ctrl_d.result_src = RES_ALU_OUT;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.retire     = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_d.alu_src_a  = ALU_A_RS1;
                ctrl_d.alu_src_b  = ALU_B_RS2;
                ctrl_d.alu_op     = ALU_OP_CMP;
                ctrl_d.result_src = RES_ALU_OUT;
                ctrl_d.pc_write   = bus.branch_taken_i;
                ctrl_d.retire     = 1'b1;
            end
            ST_JAL: begin
                ctrl_d.alu_src_a  = ALU_A_OLD_PC;
                ctrl_d.alu_src_b  = ALU_B_FOUR;
                ctrl_d.alu_op     = ALU_OP_ADD;
                ctrl_d.result_src = RES_ALU_OUT;
                ctrl_d.pc_write   = 1'b1;
            end
            ST_LUI: begin
                ctrl_d.alu_src_b  = ALU_B_IMM;
                ctrl_d.alu_op     = ALU_OP_PASS_B;
            end
            ST_AUIPC: begin
                ctrl_d.alu_src_a  = ALU_A_OLD_PC;
                ctrl_d.alu_src_b  = ALU_B_IMM;
                ctrl_d.alu_op     = ALU_OP_ADD;
            end
            default: begin
                ctrl_d.illegal    = 1'b1;
            end
        endcase
    end

    // Reset silences every strobe immediately, even mid memory transaction.
    assign ctrl = rst_ni ? ctrl_d : '0;

    assign bus.mem_req_o    = ctrl.mem_req;
    assign bus.mem_write_o  = ctrl.mem_write;
    assign bus.adr_src_o    = ctrl.adr_src;
    assign bus.ir_write_o   = ctrl.ir_write;
    assign bus.pc_write_o   = ctrl.pc_write;
    assign bus.reg_write_o  = ctrl.reg_write;
    assign bus.alu_src_a_o  = ctrl.alu_src_a;
    assign bus.alu_src_b_o  = ctrl.alu_src_b;
    assign bus.alu_op_o     = ctrl.alu_op;
    assign bus.result_src_o = ctrl.result_src;
    assign bus.retire_o     = ctrl.retire;
    assign bus.illegal_o    = ctrl.illegal;
    assign bus.imm_sel_o    = imm_sel;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: hand-computed strobe vectors per cycle.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_multi_cycle_controller;
    import risc_v_32_i_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    multi_cycle_controller_if bus ();

    multi_cycle_controller dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Vector order: mem_req mem_write adr_src ir_write pc_write reg_write a b alu_op result_src retire illegal
    task automatic expect_out(input string tag,
                              input logic mr, input logic mw, input logic as,
                              input logic iw, input logic pw, input logic rw,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] op, input logic [1:0] rs,
                              input logic ret, input logic ill);
        logic [15:0] obs;
        logic [15:0] exp;
        obs = {bus.mem_req_o, bus.mem_write_o, bus.adr_src_o, bus.ir_write_o,
               bus.pc_write_o, bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o,
               bus.alu_op_o, bus.result_src_o, bus.retire_o, bus.illegal_o};
        exp = {mr, mw, as, iw, pw, rw, a, b, op, rs, ret, ill};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_imm(input string tag, input imm_select_e exp);
        checks++;
        assert (bus.imm_sel_o === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, bus.imm_sel_o, exp);
        end
    endtask

    task automatic expect_fetch(input string tag, input logic rdy);
        expect_out(tag, 1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    endtask

    task automatic expect_decode(input string tag);
        expect_out(tag, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    endtask

    task automatic expect_quiet(input string tag);
        expect_out(tag, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    endtask

    task automatic expect_alu_wb(input string tag);
        expect_out(tag, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    endtask

    task automatic expect_fault(input string tag);
        expect_out(tag, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
    endtask

    logic [6:0] fault_ops [10];
    imm_select_e fault_imm [10];

    initial begin
        rst_n              = 1'b0;
        bus.opcode_i       = OPC_OP;
        bus.mem_ready_i    = 1'b1;
        bus.branch_taken_i = 1'b0;

        // Reset held: FETCH state but every strobe forced low.
        repeat (2) @(posedge clk);
        sample(); expect_quiet("reset_hold");

        // ADD
        step(); rst_n = 1'b1;
        sample(); expect_fetch("add_fetch", 1); expect_imm("add_imm", IMM_UNKNOWN_TYPE);
        step(); sample(); expect_decode("add_decode");
        step(); sample(); expect_out("add_exec_r", 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
        step(); sample(); expect_alu_wb("add_alu_wb");

        // LW with two wait cycles in MEM_READ
        step(); bus.opcode_i = OPC_LOAD;
        sample(); expect_fetch("lw_fetch", 1); expect_imm("lw_imm", IMM_I_TYPE);
        step(); sample(); expect_decode("lw_decode");
        step(); sample(); expect_out("lw_mem_adr", 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
        step(); bus.mem_ready_i = 1'b0;
        sample(); expect_out("lw_wait1", 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        step(); sample(); expect_out("lw_wait2", 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        step(); bus.mem_ready_i = 1'b1;
        sample(); expect_out("lw_read", 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        step(); sample(); expect_out("lw_mem_wb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0);

        // BEQ not taken
        step(); bus.opcode_i = OPC_BRANCH; bus.branch_taken_i = 1'b0;
        sample(); expect_fetch("beq_nt_fetch", 1); expect_imm("beq_imm", IMM_B_TYPE);
        step(); sample(); expect_decode("beq_nt_decode");
        step(); sample(); expect_out("beq_nt_branch", 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 1, 0);

        // BEQ taken, preceded by a fetch stall
        step(); bus.mem_ready_i = 1'b0;
        sample(); expect_fetch("beq_t_fetch_wait", 0);
        step(); bus.mem_ready_i = 1'b1;
        sample(); expect_fetch("beq_t_fetch", 1);
        step(); bus.mem_ready_i = 1'b0;
        sample(); expect_decode("beq_t_decode_rdy_ignored");
        step(); bus.branch_taken_i = 1'b1; bus.mem_ready_i = 1'b1;
        sample(); expect_out("beq_t_branch", 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'b00, 1, 0);

        // JALR -> JAL -> ALU_WB
        step(); bus.opcode_i = OPC_JALR; bus.branch_taken_i = 1'b0;
        sample(); expect_fetch("jalr_fetch", 1); expect_imm("jalr_imm", IMM_I_TYPE);
        step(); sample(); expect_decode("jalr_decode");
        step(); sample(); expect_out("jalr_jalr", 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
        step(); sample(); expect_out("jalr_jal", 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
        step(); sample(); expect_alu_wb("jalr_alu_wb");

        // LUI
        step(); bus.opcode_i = OPC_LUI;
        sample(); expect_fetch("lui_fetch", 1); expect_imm("lui_imm", IMM_U_TYPE);
        step(); sample(); expect_decode("lui_decode");
        step(); sample(); expect_out("lui_lui", 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b11, 2'b00, 0, 0);
        step(); sample(); expect_alu_wb("lui_alu_wb");

        // SW, reset dropped while memory is stalled
        step(); bus.opcode_i = OPC_STORE;
        sample(); expect_fetch("sw_fetch", 1); expect_imm("sw_imm", IMM_S_TYPE);
        step(); sample(); expect_decode("sw_decode");
        step(); sample(); expect_out("sw_mem_adr", 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
        step(); bus.mem_ready_i = 1'b0;
        sample(); expect_out("sw_wait", 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        step(); bus.mem_ready_i = 1'b1;
        #2 rst_n = 1'b0;
        #1 expect_quiet("sw_reset_abort");
        sample(); expect_quiet("sw_reset_hold");
        step(); rst_n = 1'b1;
        sample(); expect_fetch("sw_after_reset_fetch", 1);

        // Unsupported opcode traps and stays trapped whatever the inputs do
        bus.opcode_i = 7'b1110011;
        step(); sample(); expect_decode("sys_decode");
        fault_ops  = '{OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_STORE, OPC_BRANCH,
                       OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, 7'b1110011};
        fault_imm  = '{IMM_I_TYPE, IMM_I_TYPE, IMM_I_TYPE, IMM_S_TYPE, IMM_B_TYPE,
                       IMM_U_TYPE, IMM_U_TYPE, IMM_J_TYPE, IMM_UNKNOWN_TYPE, IMM_UNKNOWN_TYPE};
        for (int i = 0; i < 10; i++) begin
            step();
            bus.opcode_i    = fault_ops[i];
            bus.mem_ready_i = i[0];
            sample();
            expect_fault($sformatf("fault_hold_%0d", i));
            expect_imm($sformatf("fault_imm_%0d", i), fault_imm[i]);
        end
        #1 rst_n = 1'b0;
        #1 expect_quiet("fault_reset");
        step(); rst_n = 1'b1; bus.mem_ready_i = 1'b1;
        sample(); expect_fetch("fault_after_reset_fetch", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have no parameters; XLEN is not used, and all widths are fixed.
REQ-002 SHALL have these ports:
  - clk_i  in  1  rising-edge clock
  - rst_ni  in  1  asynchronous, active-low reset
  - opcode_i  in  7  instruction-register bits [6:0]
  - mem_ready_i  in  1  memory has completed the current request this cycle
  - branch_taken_i  in  1  datapath comparator result (funct3-qualified)
  - mem_req_o  out  1  memory request
  - mem_write_o  out  1  store strobe
  - adr_src_o  out  1  0=PC, 1=result
  - ir_write_o  out  1  latch instruction and old PC
  - pc_write_o  out  1  load PC from result
  - reg_write_o  out  1  register-file write
  - alu_src_a_o  out  2  00=PC, 01=oldPC, 10=rs1
  - alu_src_b_o  out  2  00=rs2, 01=imm, 10=const 4
  - alu_op_o  out  2  00=add, 01=compare, 10=funct decode, 11=pass B
  - result_src_o  out  2  00=ALUOut register, 01=read data, 10=ALU result
  - imm_sel_o  out  imm_select_e  selects the immediate format for the sign-extend stage
  - retire_o  out  1  final cycle of an instruction
  - illegal_o  out  1  unsupported opcode trapped

Function
REQ-003 SHALL be a Moore FSM. Outputs are functions of state only, except where mem_ready_i or branch_taken_i qualifies a strobe.
REQ-004 SHALL drive imm_sel_o combinationally from opcode_i in every state:
  - LOAD, OP-IMM, JALR -> IMM_I_TYPE
  - STORE -> IMM_S_TYPE
  - BRANCH -> IMM_B_TYPE
  - LUI, AUIPC -> IMM_U_TYPE
  - JAL -> IMM_J_TYPE
  - all other opcodes -> IMM_UNKNOWN_TYPE
REQ-005 FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=pc_write=mem_ready_i. Holds while mem_ready_i=0; goes to DECODE when mem_ready_i=1.
REQ-006 DECODE: a=01, b=01, alu_op=00 (precomputes the branch target).
  - LOAD/STORE -> MEM_ADR
  - OP -> EXEC_R
  - OP-IMM -> EXEC_I
  - BRANCH -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - LUI -> LUI
  - AUIPC -> AUIPC
  - any other opcode -> FAULT
REQ-007 MEM_ADR: a=10, b=01, alu_op=00. Goes to MEM_READ if LOAD, else MEM_WRITE.
REQ-008 MEM_READ: mem_req=1, adr_src=1, result_src=00. Waits for mem_ready_i, then goes to MEM_WB.
REQ-009 MEM_WB: result_src=01, reg_write=1, retire=1. Goes to FETCH.
REQ-010 MEM_WRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00, retire=mem_ready_i. Waits for mem_ready_i, then goes to FETCH.
REQ-011 EXEC_R (a=10, b=00, alu_op=10) and EXEC_I (a=10, b=01, alu_op=10) both go to ALU_WB.
REQ-012 ALU_WB: result_src=00, reg_write=1, retire=1. Goes to FETCH.
REQ-013 BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write=branch_taken_i, retire=1. Goes to FETCH.
REQ-014 JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Goes to ALU_WB, which writes oldPC+4.
REQ-015 JALR: a=10, b=01, alu_op=00. Goes to JAL.
REQ-016 LUI (b=01, alu_op=11) and AUIPC (a=01, b=01, alu_op=00) both go to ALU_WB.
REQ-017 FAULT: every strobe is 0 and illegal_o=1. The state is absorbing until reset.
REQ-018 In every state, any output not listed for it SHALL be 0.
REQ-019 Cycle counts, excluding memory wait states:
  - R / I / LUI / AUIPC / store / JAL: 4 cycles
  - load / JALR: 5 cycles
  - branch: 3 cycles
REQ-020 mem_ready_i asserted in a state without mem_req_o SHALL be ignored.

Reset
REQ-021 While rst_ni=0, SHALL asynchronously force state FETCH and drive all strobes plus retire_o and illegal_o to 0 (mem_req_o included).
REQ-022 Reset asserted mid-instruction (including during a memory wait) SHALL abandon it with no further strobes.
REQ-023 The first cycle after rst_ni rises SHALL be FETCH with mem_req_o=1.

Structure
REQ-024 The state enum (ctrl_state_e), the opcode constants and the mux-select encodings SHALL live in risc_v_32_i_pkg, alongside imm_select_e.
REQ-025 The opcode-to-imm_sel decode SHALL be a sub-module, imm_select_decoder, which is reusable by the single-cycle processor.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - ADD (0110011), mem_ready_i=1 throughout -> FETCH, DECODE, EXEC_R, ALU_WB; reg_write and retire both high in cycle 4; imm_sel=IMM_UNKNOWN_TYPE.
  - LW (0000011), mem_ready_i low for 2 cycles in MEM_READ -> 7 cycles total; result_src=01 in MEM_WB; imm_sel=IMM_I_TYPE.
  - BEQ (1100011) with branch_taken_i=0, then again with branch_taken_i=1 -> 3 cycles each; pc_write in BRANCH is 0 and 1 respectively; imm_sel=IMM_B_TYPE.
  - JALR (1100111) -> JALR, JAL, ALU_WB; pc_write=1 exactly once, in the JAL state.
  - Opcode 1110011 -> FAULT with illegal_o=1 held for 10 cycles; rst_ni low returns to FETCH.
  - rst_ni dropped during a MEM_WRITE wait -> mem_write_o falls in the same cycle, with no retire.
